sp_bank_arbiter: RTL

- Sits in front of one scratchpad bank.
- Arbitrates the two producers of bank write requests (DRAM load path, GEMM result writeback) onto the bank's write FIFO, and the two producers of bank read requests (DRAM store path, GEMM operand fetch) onto its read FIFO.
- Caps in-flight traffic with outstanding counters and implements a fence that drains the bank before a phase change.

---
 rtl/sp_bank_arbiter_if.sv | 50 +++++
 rtl/sp_bank_arbiter.sv | 91 +++++++++
 2 files changed

// File: rtl/sp_bank_arbiter_if.sv
// Request/grant bundle between the bank's four requesters, its two FIFOs and the fence/status logic.
interface sp_bank_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 64
);
   logic              dw_req;
   logic [ADDR_W-1:0] dw_addr;
   logic [DATA_W-1:0] dw_data;
   logic              gw_req;
   logic [ADDR_W-1:0] gw_addr;
   logic [DATA_W-1:0] gw_data;
   logic              dw_ack;
   logic              gw_ack;
   logic              dr_req;
   logic [ADDR_W-1:0] dr_addr;
   logic              gr_req;
   logic [ADDR_W-1:0] gr_addr;
   logic              dr_ack;
   logic              gr_ack;
   logic                     wFIFO_WEN;
   logic [ADDR_W+DATA_W-1:0] wFIFO_wdata;
   logic                     rFIFO_WEN;
   logic [ADDR_W:0]          rFIFO_wdata;
   logic              wFIFO_full;
   logic              rFIFO_full;
   logic              load_complete;
   logic              gemm_complete;
   logic              fence_req;
   logic              fence_done;
   logic              busy;
   logic              cnt_err;

   modport slave (
      input  dw_req, dw_addr, dw_data, gw_req, gw_addr, gw_data,
      input  dr_req, dr_addr, gr_req, gr_addr,
      input  wFIFO_full, rFIFO_full, load_complete, gemm_complete, fence_req,
      output dw_ack, gw_ack, dr_ack, gr_ack,
      output wFIFO_WEN, wFIFO_wdata, rFIFO_WEN, rFIFO_wdata,
      output fence_done, busy, cnt_err
   );

   modport master (
      output dw_req, dw_addr, dw_data, gw_req, gw_addr, gw_data,
      output dr_req, dr_addr, gr_req, gr_addr,
      output wFIFO_full, rFIFO_full, load_complete, gemm_complete, fence_req,
      input  dw_ack, gw_ack, dr_ack, gr_ack,
      input  wFIFO_WEN, wFIFO_wdata, rFIFO_WEN, rFIFO_wdata,
      input  fence_done, busy, cnt_err
   );
endinterface

// File: rtl/sp_bank_arbiter.sv
// Round-robin write/read arbiter for one scratchpad bank with outstanding-count caps and a drain fence.
//
// state | meaning
// IDLE  | grants allowed on both channels
// FENCE | grants blocked, waiting for both outstanding counts to drain to zero
// DONE  | fence_done pulses for one cycle, then back to IDLE
module sp_bank_arbiter #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 64,
   parameter int MAX_OUT = 8
) (
   input  logic CLK,
   input  logic nRST,
   sp_bank_arbiter_if.slave bus
);
   localparam int CW = $clog2(MAX_OUT + 1);

   typedef enum logic [1:0] {IDLE, FENCE, DONE} state_t;

   state_t        state;
   logic [CW-1:0] wCnt, rCnt, wCntNext, rCntNext;
   logic          wLast, rLast;
   logic          wElig, rElig;
   logic          wGrant0, wGrant1, rGrant0, rGrant1;
   logic          wUnder, rUnder;
   logic          fenceDone, busyReg, cntErr;

   function automatic logic [CW-1:0] nextCnt(input logic [CW-1:0] c, input logic inc, input logic dec);
      if (inc && !dec)                return c + 1'b1;
      else if (dec && !inc && c != '0) return c - 1'b1;
      else                            return c;
   endfunction

   // Eligibility looks at the registered count, so a same-cycle completion never unblocks a full channel.
   always_comb begin
      wElig   = nRST && (state == IDLE) && !bus.wFIFO_full && (wCnt < CW'(MAX_OUT));
      rElig   = nRST && (state == IDLE) && !bus.rFIFO_full && (rCnt < CW'(MAX_OUT));
      wGrant0 = wElig && bus.dw_req && (!bus.gw_req || wLast);
      wGrant1 = wElig && bus.gw_req && (!bus.dw_req || !wLast);
      rGrant0 = rElig && bus.dr_req && (!bus.gr_req || rLast);
      rGrant1 = rElig && bus.gr_req && (!bus.dr_req || !rLast);
      wCntNext = nextCnt(wCnt, wGrant0 | wGrant1, bus.load_complete);
      rCntNext = nextCnt(rCnt, rGrant0 | rGrant1, bus.gemm_complete);
      wUnder   = bus.load_complete && !(wGrant0 | wGrant1) && (wCnt == '0);
      rUnder   = bus.gemm_complete && !(rGrant0 | rGrant1) && (rCnt == '0);
   end

   assign bus.dw_ack      = wGrant0;
   assign bus.gw_ack      = wGrant1;
   assign bus.dr_ack      = rGrant0;
   assign bus.gr_ack      = rGrant1;
   assign bus.wFIFO_WEN   = wGrant0 | wGrant1;
   assign bus.rFIFO_WEN   = rGrant0 | rGrant1;
   assign bus.wFIFO_wdata = wGrant1 ? {bus.gw_addr, bus.gw_data} : {bus.dw_addr, bus.dw_data};
   assign bus.rFIFO_wdata = rGrant1 ? {1'b1, bus.gr_addr} : {1'b0, bus.dr_addr};
   assign bus.fence_done  = fenceDone;
   assign bus.busy        = busyReg;
   assign bus.cnt_err     = cntErr;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state     <= IDLE;
         wCnt      <= '0;
         rCnt      <= '0;
         wLast     <= 1'b1;
         rLast     <= 1'b1;
         fenceDone <= 1'b0;
         busyReg   <= 1'b0;
         cntErr    <= 1'b0;
      end else begin
         wCnt      <= wCntNext;
         rCnt      <= rCntNext;
         busyReg   <= (wCntNext != '0) || (rCntNext != '0);
         fenceDone <= 1'b0;
         if (wGrant0 || wGrant1) wLast <= wGrant1;
         if (rGrant0 || rGrant1) rLast <= rGrant1;
         if (wUnder || rUnder)   cntErr <= 1'b1;
         case (state)
            IDLE:    if (bus.fence_req) state <= FENCE;
            FENCE: begin
               if (wCntNext == '0 && rCntNext == '0) begin
                  state     <= DONE;
                  fenceDone <= 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
